// File: rtl/alu_pkg.sv
// Opcode and sub-function encodings shared by the sequential ALU and its controller.
package alu_pkg;

    localparam logic [3:0] OP_SHL  = 4'b0010;
    localparam logic [3:0] OP_SHR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_LOG  = 4'b0101;
    localparam logic [3:0] OP_CMP  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_MOV  = 4'b1011;
    localparam logic [3:0] OP_ROT  = 4'b1100;
    localparam logic [3:0] OP_ADDI = 4'b1101;
    localparam logic [3:0] OP_SUBI = 4'b1110;

    // OP_ADD
    localparam logic [1:0] FN_ADD  = 2'b00;
    localparam logic [1:0] FN_ADC  = 2'b01;
    localparam logic [1:0] FN_SUB  = 2'b10;
    localparam logic [1:0] FN_SBC  = 2'b11;
    // OP_LOG
    localparam logic [1:0] FN_OR   = 2'b00;
    localparam logic [1:0] FN_AND  = 2'b01;
    localparam logic [1:0] FN_XOR  = 2'b10;
    localparam logic [1:0] FN_NAND = 2'b11;
    // OP_CMP
    localparam logic [1:0] FN_EQ   = 2'b00;
    localparam logic [1:0] FN_LT   = 2'b01;
    localparam logic [1:0] FN_GT   = 2'b10;
    localparam logic [1:0] FN_NONE = 2'b11;
    // OP_ROT / OP_MOV
    localparam logic [1:0] FN_RL   = 2'b00;
    localparam logic [1:0] FN_RR   = 2'b01;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, W cycles per result.
module mul_shift_add #(
    parameter int unsigned W = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] prod
);

    localparam int unsigned CW = $clog2(W + 1);

    logic           busy_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_nxt;

    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy    = busy_q;
    // Strobe for the edge that completes the final step; prod is valid alongside it.
    assign done    = busy_q && (cnt_q == CW'(1));
    assign prod    = acc_nxt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end else if (start) begin
            mcand_q  <= {{W{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= CW'(W);
            busy_q   <= 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with C/Z/branch flag registers, start/done handshake and multi-cycle multiply.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned IMMW = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [3:0]      OP,
    input  logic [1:0]      funct,
    input  logic [IMMW-1:0] imm,
    input  logic [W-1:0]    InputA,
    input  logic [W-1:0]    InputB,
    output logic [W-1:0]    Out,
    output logic [W-1:0]    OutHi,
    output logic            carry,
    output logic            zero,
    output logic            branch,
    output logic            busy,
    output logic            done
);

    logic [W-1:0] out_q, out_d, out_hi_q, out_hi_d;
    logic         carry_q, carry_d, zero_q, zero_d, branch_q, branch_d, done_q, done_d;
    logic         wr_res;

    logic           mul_busy, mul_done, mul_start, accept;
    logic [2*W-1:0] mul_prod;

    logic [IMMW:0] k;
    logic [W-1:0]  k_w;
    logic          cin;
    logic [W:0]    shl_w, shr_w, sum_w, dif_w;

    assign accept    = Start & ~mul_busy;
    assign mul_start = accept & (OP == OP_MUL);

    assign k     = {1'b0, imm} + {{IMMW{1'b0}}, 1'b1};
    assign k_w   = {{(W-IMMW-1){1'b0}}, k};
    assign cin   = funct[0] & carry_q;
    // Extra bit on each side captures the last bit shifted out as the carry.
    assign shl_w = {1'b0, InputB} << k;
    assign shr_w = {InputB, 1'b0} >> k;
    assign sum_w = {1'b0, InputA} + {1'b0, InputB} + {{W{1'b0}}, cin};
    assign dif_w = {1'b0, InputB} - {1'b0, InputA} - {{W{1'b0}}, cin};

    mul_shift_add #(
        .W (W)
    ) u_mul (
        .Clk   (Clk),
        .Reset (Reset),
        .start (mul_start),
        .a     (InputA),
        .b     (InputB),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        out_d    = out_q;
        out_hi_d = out_hi_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        branch_d = branch_q;
        done_d   = 1'b0;
        wr_res   = 1'b0;

        if (mul_done) begin
            out_d    = mul_prod[W-1:0];
            out_hi_d = mul_prod[2*W-1:W];
            carry_d  = |mul_prod[2*W-1:W];
            zero_d   = (mul_prod == '0);
            done_d   = 1'b1;
        end else if (accept && (OP != OP_MUL)) begin
            done_d = 1'b1;
            wr_res = 1'b1;
            case (OP)
                OP_SHL: begin
                    out_d   = shl_w[W-1:0];
                    carry_d = shl_w[W];
                end
                OP_SHR: begin
                    out_d   = shr_w[W:1];
                    carry_d = shr_w[0];
                end
                OP_ADD: begin
                    if (funct[1]) {carry_d, out_d} = dif_w;
                    else          {carry_d, out_d} = sum_w;
                end
                OP_LOG: begin
                    case (funct)
                        FN_OR:   out_d = InputA | InputB;
                        FN_AND:  out_d = InputA & InputB;
                        FN_XOR:  out_d = InputA ^ InputB;
                        default: out_d = ~(InputA & InputB);
                    endcase
                end
                OP_CMP: begin
                    wr_res = 1'b0;
                    case (funct)
                        FN_EQ:   branch_d = (InputA == InputB);
                        FN_LT:   branch_d = (InputA < InputB);
                        FN_GT:   branch_d = (InputA > InputB);
                        default: branch_d = 1'b0;
                    endcase
                end
                OP_MOV: out_d = (funct == 2'b00) ? InputA : InputB;
                OP_ROT: begin
                    case (funct)
                        FN_RL: begin
                            out_d   = {InputB[W-2:0], carry_q};
                            carry_d = InputB[W-1];
                        end
                        FN_RR: begin
                            out_d   = {carry_q, InputB[W-1:1]};
                            carry_d = InputB[0];
                        end
                        default: out_d = InputB;
                    endcase
                end
                OP_ADDI: out_d = InputB + k_w;
                OP_SUBI: out_d = InputB - k_w;
                default: out_d = '0;
            endcase
            if (wr_res) begin
                out_hi_d = '0;
                zero_d   = (out_d == '0);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_q    <= '0;
            out_hi_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            branch_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            branch_q <= branch_d;
            done_q   <= done_d;
        end
    end

    assign Out    = out_q;
    assign OutHi  = out_hi_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign branch = branch_q;
    assign busy   = mul_busy;
    assign done   = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (W=8, IMMW=2) with hand-computed expectations.
module tb_seq_alu;

    logic       Clk = 1'b0;
    logic       Reset, Start;
    logic [3:0] OP;
    logic [1:0] funct;
    logic [1:0] imm;
    logic [7:0] InputA, InputB;
    logic [7:0] Out, OutHi;
    logic       carry, zero, branch, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    seq_alu #(
        .W    (8),
        .IMMW (2)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .OP     (OP),
        .funct  (funct),
        .imm    (imm),
        .InputA (InputA),
        .InputB (InputB),
        .Out    (Out),
        .OutHi  (OutHi),
        .carry  (carry),
        .zero   (zero),
        .branch (branch),
        .busy   (busy),
        .done   (done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [3:0] op, input logic [1:0] fn,
                         input logic [1:0] im, input logic [7:0] a, input logic [7:0] b);
        Start  = s;
        OP     = op;
        funct  = fn;
        imm    = im;
        InputA = a;
        InputB = b;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks {OutHi,Out}, carry, zero, branch, busy, done in one go.
    task automatic chk_all(input string tag, input logic [15:0] res, input logic c,
                           input logic z, input logic br, input logic bz, input logic dn);
        chk({tag, ".res"},    {OutHi, Out}, res);
        chk({tag, ".carry"},  {15'd0, carry}, {15'd0, c});
        chk({tag, ".zero"},   {15'd0, zero}, {15'd0, z});
        chk({tag, ".branch"}, {15'd0, branch}, {15'd0, br});
        chk({tag, ".busy"},   {15'd0, busy}, {15'd0, bz});
        chk({tag, ".done"},   {15'd0, done}, {15'd0, dn});
    endtask

    initial begin
        // Reset with Start held high and an ADD pending
        Reset = 1'b1;
        drive(1'b1, 4'b0100, 2'b00, 2'd0, 8'hF0, 8'h20);
        tick();
        chk_all("rst0", 16'h0000, 0, 0, 0, 0, 0);
        tick();
        chk_all("rst1", 16'h0000, 0, 0, 0, 0, 0);
        Reset = 1'b0;

        tick();  // first edge after reset accepts the ADD
        chk_all("add", 16'h0010, 1, 0, 0, 0, 1);

        drive(1'b1, 4'b0100, 2'b01, 2'd0, 8'h01, 8'h01);
        tick();
        chk_all("adc", 16'h0003, 0, 0, 0, 0, 1);

        drive(1'b1, 4'b0100, 2'b10, 2'd0, 8'h05, 8'h03);
        tick();
        chk_all("sub", 16'h00FE, 1, 0, 0, 0, 1);

        drive(1'b1, 4'b0110, 2'b01, 2'd0, 8'h03, 8'h05);
        tick();
        chk_all("cmp_lt", 16'h00FE, 1, 0, 1, 0, 1);

        drive(1'b1, 4'b0010, 2'b00, 2'd1, 8'h00, 8'h40);
        tick();
        chk_all("shl", 16'h0000, 1, 1, 1, 0, 1);

        drive(1'b1, 4'b1100, 2'b01, 2'd0, 8'h00, 8'h01);
        tick();
        chk_all("rotr", 16'h0080, 1, 0, 1, 0, 1);

        drive(1'b1, 4'b0101, 2'b10, 2'd0, 8'h0F, 8'hFF);
        tick();
        chk_all("xor", 16'h00F0, 1, 0, 1, 0, 1);

        drive(1'b1, 4'b0110, 2'b11, 2'd0, 8'h00, 8'h00);
        tick();
        chk_all("cmp_none", 16'h00F0, 1, 0, 0, 0, 1);

        drive(1'b1, 4'b0011, 2'b00, 2'd3, 8'h00, 8'h18);
        tick();
        chk_all("shr", 16'h0001, 1, 0, 0, 0, 1);

        drive(1'b1, 4'b1101, 2'b00, 2'd3, 8'h00, 8'hFE);
        tick();
        chk_all("addi", 16'h0002, 1, 0, 0, 0, 1);

        drive(1'b1, 4'b1110, 2'b00, 2'd0, 8'h00, 8'h00);
        tick();
        chk_all("subi", 16'h00FF, 1, 0, 0, 0, 1);

        drive(1'b1, 4'b1011, 2'b00, 2'd0, 8'h5A, 8'h33);
        tick();
        chk_all("mov", 16'h005A, 1, 0, 0, 0, 1);

        drive(1'b1, 4'b0000, 2'b00, 2'd0, 8'h12, 8'h34);
        tick();
        chk_all("op0", 16'h0000, 1, 1, 0, 0, 1);

        drive(1'b0, 4'b0100, 2'b00, 2'd0, 8'h12, 8'h34);
        tick();
        chk_all("idle", 16'h0000, 1, 1, 0, 0, 0);

        // MUL 0xFF*0xFF with a competing Start and changing operands while busy
        drive(1'b1, 4'b0111, 2'b00, 2'd0, 8'hFF, 8'hFF);
        tick();
        chk_all("mul_e0", 16'h0000, 1, 1, 0, 1, 0);
        drive(1'b1, 4'b0100, 2'b00, 2'd0, 8'h01, 8'h01);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_all($sformatf("mul_e%0d", i), 16'h0000, 1, 1, 0, 1, 0);
        end
        tick();
        chk_all("mul_done", 16'hFE01, 1, 0, 0, 0, 1);
        drive(1'b0, 4'b0000, 2'b00, 2'd0, 8'h00, 8'h00);
        tick();
        chk_all("mul_after", 16'hFE01, 1, 0, 0, 0, 0);

        // Reset in the middle of a MUL aborts it without a done pulse
        drive(1'b1, 4'b0111, 2'b00, 2'd0, 8'h12, 8'h34);
        tick();
        drive(1'b0, 4'b0000, 2'b00, 2'd0, 8'h00, 8'h00);
        for (int i = 1; i < 4; i++) tick();
        chk_all("mul_c4", 16'hFE01, 1, 0, 0, 1, 0);
        Reset = 1'b1;
        tick();
        chk_all("mul_abort", 16'h0000, 0, 0, 0, 0, 0);
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all($sformatf("post_abort%0d", i), 16'h0000, 0, 0, 0, 0, 0);
        end

        drive(1'b1, 4'b0111, 2'b11, 2'd0, 8'h03, 8'h04);
        tick();
        drive(1'b0, 4'b0000, 2'b00, 2'd0, 8'h00, 8'h00);
        chk_all("mul2_e0", 16'h0000, 0, 0, 0, 1, 0);
        for (int i = 1; i < 8; i++) tick();
        chk_all("mul2_e7", 16'h0000, 0, 0, 0, 1, 0);
        tick();
        chk_all("mul2_done", 16'h000C, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
